// File: rtl/gost_pkg.sv
// Shared constants, types, S-box table and key schedule for the GOST 28147-89 core.
package gost_pkg;

    localparam int unsigned BLOCK_W = 64;
    localparam int unsigned KEY_W   = 256;
    localparam int unsigned ROUNDS  = 32;
    localparam int unsigned HALF_W  = 32;
    localparam int unsigned NKEYS   = 8;
    localparam int unsigned RND_W   = 5;
    localparam int unsigned KIDX_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [HALF_W-1:0] l;
        logic [HALF_W-1:0] r;
    } block_t;

    // Index NKEYS-1 holds K0 (key_i[255:224]), index 0 holds K7.
    typedef logic [NKEYS-1:0][HALF_W-1:0] key_t;

    // SBOX[j][n]: S-box S(j+1) applied to nibble j of the round sum.
    localparam logic [3:0] SBOX [NKEYS][16] = '{
        '{4'h4, 4'hA, 4'h9, 4'h2, 4'hD, 4'h8, 4'h0, 4'hE, 4'h6, 4'hB, 4'h1, 4'hC, 4'h7, 4'hF, 4'h5, 4'h3},
        '{4'hE, 4'hB, 4'h4, 4'hC, 4'h6, 4'hD, 4'hF, 4'hA, 4'h2, 4'h3, 4'h8, 4'h1, 4'h0, 4'h7, 4'h5, 4'h9},
        '{4'h5, 4'h8, 4'h1, 4'hD, 4'hA, 4'h3, 4'h4, 4'h2, 4'hE, 4'hF, 4'hC, 4'h7, 4'h6, 4'h0, 4'h9, 4'hB},
        '{4'h7, 4'hD, 4'hA, 4'h1, 4'h0, 4'h8, 4'h9, 4'hF, 4'hE, 4'h4, 4'h6, 4'hC, 4'hB, 4'h2, 4'h5, 4'h3},
        '{4'h6, 4'hC, 4'h7, 4'h1, 4'h5, 4'hF, 4'hD, 4'h8, 4'h4, 4'hA, 4'h9, 4'hE, 4'h0, 4'h3, 4'hB, 4'h2},
        '{4'h4, 4'hB, 4'hA, 4'h0, 4'h7, 4'h2, 4'h1, 4'hD, 4'h3, 4'h6, 4'h8, 4'h5, 4'h9, 4'hC, 4'hF, 4'hE},
        '{4'hD, 4'hB, 4'h4, 4'h1, 4'h3, 4'hF, 4'h5, 4'h9, 4'h0, 4'hA, 4'hE, 4'h7, 4'h6, 4'h8, 4'h2, 4'hC},
        '{4'h1, 4'hF, 4'hD, 4'h0, 4'h5, 4'h7, 4'hA, 4'h4, 4'h9, 4'h2, 4'h3, 4'hE, 4'h6, 4'hB, 4'h8, 4'hC}
    };

    // Subkey number for a round: forward order, then reversed for the last 8 (enc) or last 24 (dec).
    function automatic logic [KIDX_W-1:0] key_idx(input logic [RND_W-1:0] rnd, input logic enc);
        logic rev;
        rev = enc ? (rnd >= RND_W'(24)) : (rnd >= RND_W'(8));
        return rev ? (KIDX_W'(7) - rnd[KIDX_W-1:0]) : rnd[KIDX_W-1:0];
    endfunction

endpackage

// File: rtl/gost_round.sv
// One combinational GOST Feistel round: substitution, rotate-left-11, XOR into L, swap.
module gost_round
    import gost_pkg::*;
(
    input  logic [HALF_W-1:0] i_l,
    input  logic [HALF_W-1:0] i_r,
    input  logic [HALF_W-1:0] i_k,
    output logic [HALF_W-1:0] o_l_c,
    output logic [HALF_W-1:0] o_r_c
);

    logic [HALF_W-1:0] w_sum;
    logic [HALF_W-1:0] w_sub;
    logic [HALF_W-1:0] w_rot;

    assign w_sum = i_r + i_k;

    for (genvar j = 0; j < int'(NKEYS); j++) begin : g_sbox
        assign w_sub[4*j +: 4] = SBOX[j][w_sum[4*j +: 4]];
    end

    assign w_rot = {w_sub[HALF_W-12:0], w_sub[HALF_W-1:HALF_W-11]};
    assign o_l_c = i_r;
    assign o_r_c = i_l ^ w_rot;

endmodule

// File: rtl/criptografia_gost.sv
// Iterative GOST 28147-89 block cipher: one round per clock behind a start/busy/ready handshake.
module criptografia_gost
    import gost_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               enc_dec,
    input  logic [BLOCK_W-1:0] data_i,
    input  logic [KEY_W-1:0]   key_i,
    output logic [BLOCK_W-1:0] data_o,
    output logic               busy,
    output logic               ready_o
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [HALF_W-1:0]  r_l;
    logic [HALF_W-1:0]  r_r;
    logic [HALF_W-1:0]  w_l_nxt;
    logic [HALF_W-1:0]  w_r_nxt;
    key_t               r_key;
    key_t               w_key_nxt;
    logic               r_mode;
    logic               w_mode_nxt;
    logic [RND_W-1:0]   r_round;
    logic [RND_W-1:0]   w_round_nxt;
    logic [BLOCK_W-1:0] r_data_o;
    logic [BLOCK_W-1:0] w_data_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               r_ready;
    logic               w_ready_nxt;

    block_t             w_in;
    logic [KIDX_W-1:0]  w_kidx;
    logic [HALF_W-1:0]  w_subkey;
    logic [HALF_W-1:0]  w_l_rnd;
    logic [HALF_W-1:0]  w_r_rnd;

    assign w_in     = data_i;
    assign w_kidx   = key_idx(r_round, r_mode);
    assign w_subkey = r_key[KIDX_W'(7) - w_kidx];

    gost_round u_round (
        .i_l   (r_l),
        .i_r   (r_r),
        .i_k   (w_subkey),
        .o_l_c (w_l_rnd),
        .o_r_c (w_r_rnd)
    );

    // Next-state and datapath control.
    always_comb begin
        w_state_nxt = r_state;
        w_l_nxt     = r_l;
        w_r_nxt     = r_r;
        w_key_nxt   = r_key;
        w_mode_nxt  = r_mode;
        w_round_nxt = r_round;
        w_data_nxt  = r_data_o;
        w_busy_nxt  = r_busy;
        w_ready_nxt = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_l_nxt     = w_in.l;
                    w_r_nxt     = w_in.r;
                    w_key_nxt   = key_i;
                    w_mode_nxt  = enc_dec;
                    w_round_nxt = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_l_nxt     = w_l_rnd;
                w_r_nxt     = w_r_rnd;
                w_round_nxt = r_round + RND_W'(1);
                if (r_round == RND_W'(ROUNDS - 1)) begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // The final swap is not undone: R goes out in the upper half.
                w_data_nxt  = {r_r, r_l};
                w_ready_nxt = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_l      <= '0;
            r_r      <= '0;
            r_key    <= '0;
            r_mode   <= 1'b0;
            r_round  <= '0;
            r_data_o <= '0;
            r_busy   <= 1'b0;
            r_ready  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_l      <= w_l_nxt;
            r_r      <= w_r_nxt;
            r_key    <= w_key_nxt;
            r_mode   <= w_mode_nxt;
            r_round  <= w_round_nxt;
            r_data_o <= w_data_nxt;
            r_busy   <= w_busy_nxt;
            r_ready  <= w_ready_nxt;
        end
    end

    assign data_o  = r_data_o;
    assign busy    = r_busy;
    assign ready_o = r_ready;

endmodule

// File: tb/tb_criptografia_gost.sv
// Directed and random checks of the GOST core against an independent behavioural model.
module tb_criptografia_gost;

    localparam logic [255:0] KEY_A = 256'hDEADBEEF0123456789ABCDEFDEADBEEFDEADBEEF0123456789ABCDEFDEADBEEF;
    localparam logic [255:0] KEY_B = 256'h0011223344556677_8899AABBCCDDEEFF_FEDCBA9876543210_0F1E2D3C4B5A6978;
    localparam logic [63:0]  PT_A  = 64'hA5A5A5A501234567;
    localparam logic [63:0]  PT_B  = 64'h0123456789ABCDEF;

    // Row j is S(j+1); nibble for input n sits at bits [63-4n -: 4].
    localparam logic [63:0] SB [8] = '{
        64'h4A92D80E6B1C7F53,
        64'hEB4C6DFA23810759,
        64'h581DA342EFC7609B,
        64'h7DA1089FE46CB253,
        64'h6C715FD84A9E03B2,
        64'h4BA0721D36859CFE,
        64'hDB413F590AE7682C,
        64'h1FD057A4923E6B8C
    };

    logic         clock   = 1'b0;
    logic         reset   = 1'b0;
    logic         start   = 1'b0;
    logic         enc_dec = 1'b0;
    logic [63:0]  data_i  = '0;
    logic [255:0] key_i   = '0;
    logic [63:0]  data_o;
    logic         busy;
    logic         ready_o;

    int errors = 0;
    int checks = 0;

    criptografia_gost dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .enc_dec (enc_dec),
        .data_i  (data_i),
        .key_i   (key_i),
        .data_o  (data_o),
        .busy    (busy),
        .ready_o (ready_o)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] model(input logic [255:0] key, input logic [63:0] blk, input logic enc);
        logic [31:0] n1, n2, t, s, k, tmp;
        logic [63:0] row;
        logic [3:0]  nib;
        int          idx;
        n2 = blk[63:32];
        n1 = blk[31:0];
        for (int i = 0; i < 32; i++) begin
            if (enc) idx = (i < 24) ? (i % 8) : (31 - i);
            else     idx = (i < 8) ? i : (7 - (i % 8));
            k = key[255 - 32*idx -: 32];
            t = n1 + k;
            for (int j = 0; j < 8; j++) begin
                row = SB[j];
                nib = t[4*j +: 4];
                s[4*j +: 4] = row[63 - 4*int'(nib) -: 4];
            end
            s   = {s[20:0], s[31:21]};
            tmp = n2 ^ s;
            n2  = n1;
            n1  = tmp;
        end
        return {n1, n2};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one block; start held for 'hold' edges and all inputs scrambled after the first edge.
    task automatic run_op(input logic [255:0] key, input logic [63:0] blk, input logic enc, input int hold,
                          output logic [63:0] res, output int lat, output int bcnt, output int rcnt);
        @(negedge clock);
        key_i   = key;
        data_i  = blk;
        enc_dec = enc;
        start   = 1'b1;
        @(posedge clock);
        #1;
        res  = '0;
        lat  = -1;
        rcnt = 0;
        bcnt = busy ? 1 : 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            start   = (k < hold);
            data_i  = ~data_i;
            key_i   = ~key_i;
            enc_dec = ~enc_dec;
            @(posedge clock);
            #1;
            if (busy) bcnt++;
            if (ready_o) begin
                rcnt++;
                if (lat < 0) begin
                    lat = k;
                    res = data_o;
                end
            end
        end
    endtask

    initial begin
        logic [63:0] c, p, r, first, second, ref_c;
        logic [255:0] rk;
        int lat, bcnt, rcnt, r1_edge, r2_edge, hold_bad, late_ready, late_busy;

        // Reset state.
        #1;
        check("rst_data_o", data_o, 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_ready", 64'(ready_o), 64'h0);
        @(negedge clock);
        reset = 1'b1;

        // Encrypt the reference block.
        ref_c = model(KEY_A, PT_A, 1'b1);
        run_op(KEY_A, PT_A, 1'b1, 1, c, lat, bcnt, rcnt);
        check("enc_data", c, ref_c);
        check("enc_latency", 64'(lat), 64'd33);
        check("enc_busy_cycles", 64'(bcnt), 64'd32);
        check("enc_ready_pulses", 64'(rcnt), 64'd1);
        check("enc_data_hold", data_o, ref_c);

        // Decrypt it back to the known plaintext.
        run_op(KEY_A, c, 1'b0, 1, p, lat, bcnt, rcnt);
        check("dec_data", p, 64'hA5A5A5A501234567);
        check("dec_latency", 64'(lat), 64'd33);
        check("dec_ready_pulses", 64'(rcnt), 64'd1);

        // Start held 3 cycles with changing inputs.
        run_op(KEY_B, PT_B, 1'b1, 3, r, lat, bcnt, rcnt);
        check("hold_data", r, model(KEY_B, PT_B, 1'b1));
        check("hold_ready_pulses", 64'(rcnt), 64'd1);
        check("hold_busy_cycles", 64'(bcnt), 64'd32);

        // Back-to-back: second start the cycle after ready_o.
        @(negedge clock);
        key_i   = KEY_A;
        data_i  = PT_A;
        enc_dec = 1'b1;
        start   = 1'b1;
        @(posedge clock);
        #1;
        r1_edge  = -1;
        r2_edge  = -1;
        hold_bad = 0;
        first    = '0;
        second   = '0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clock);
            start = (r1_edge >= 0) && (k == r1_edge + 1);
            if (start) data_i = PT_B;
            else       data_i = ~data_i;
            @(posedge clock);
            #1;
            if (ready_o) begin
                if (r1_edge < 0) begin
                    r1_edge = k;
                    first   = data_o;
                end else if (r2_edge < 0) begin
                    r2_edge = k;
                    second  = data_o;
                end
            end else if (r1_edge >= 0 && r2_edge < 0 && data_o !== first) begin
                hold_bad++;
            end
        end
        check("b2b_first", first, ref_c);
        check("b2b_first_edge", 64'(r1_edge), 64'd33);
        check("b2b_gap", 64'(r2_edge - r1_edge), 64'd34);
        check("b2b_second", second, model(KEY_A, PT_B, 1'b1));
        check("b2b_hold_between", 64'(hold_bad), 64'd0);

        // Reset mid-RUN aborts the block.
        @(negedge clock);
        key_i   = KEY_B;
        data_i  = PT_A;
        enc_dec = 1'b1;
        start   = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (10) @(negedge clock);
        reset = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'h0);
        check("midrst_ready", 64'(ready_o), 64'h0);
        check("midrst_data_o", data_o, 64'h0);
        @(negedge clock);
        reset      = 1'b1;
        late_ready = 0;
        late_busy  = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock);
            #1;
            if (ready_o) late_ready++;
            if (busy)    late_busy++;
        end
        check("midrst_no_ready", 64'(late_ready), 64'd0);
        check("midrst_no_busy", 64'(late_busy), 64'd0);
        check("midrst_data_stays", data_o, 64'h0);

        // Random round trips.
        for (int n = 0; n < 100; n++) begin
            rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            p  = {$urandom, $urandom};
            run_op(rk, p, 1'b1, 1, c, lat, bcnt, rcnt);
            check("rand_enc", c, model(rk, p, 1'b1));
            run_op(rk, c, 1'b0, 1, r, lat, bcnt, rcnt);
            check("rand_dec", r, p);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
